// File: rtl/program_counter_pkg.sv
// Shared fetch-stage PC definitions: reset value, default step and the
// select encoding used by the next-PC mux.
package program_counter_pkg;

  localparam int PC_RESET_VALUE  = 0;
  localparam int PC_STEP_DEFAULT = 4;

  typedef enum logic [1:0] {
    PC_SEL_HOLD    = 2'd0,
    PC_SEL_ADVANCE = 2'd1,
    PC_SEL_LOAD    = 2'd2
  } pc_sel_e;

  // Load outranks advance; with neither requested the PC holds.
  function automatic pc_sel_e pc_select(input logic load_en, input logic pc_next);
    pc_sel_e sel;
    sel = PC_SEL_HOLD;
    if (load_en) begin
      sel = PC_SEL_LOAD;
    end else if (pc_next) begin
      sel = PC_SEL_ADVANCE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/program_counter_if.sv
// Fetch-stage PC bus: control and load target from the core, registered pc back.
interface program_counter_if #(
  parameter int pcen  = 32,
  parameter int pcout = 32
);

  logic             load_en;
  logic             pc_next;
  logic [pcen:0]    load;
  logic [pcout:0]   pc;

  modport master (output load_en, output pc_next, output load, input pc);
  modport slave  (input load_en, input pc_next, input load, output pc);

endinterface

// File: rtl/program_counter_pc_next_mux.sv
// Combinational priority select of the next PC: load target, pc + step, or hold.
module pc_next_mux
  import program_counter_pkg::*;
#(
  parameter int PCW    = 33,
  parameter int pcstep = PC_STEP_DEFAULT
) (
  input  logic           load_en,
  input  logic           pc_next,
  input  logic [PCW-1:0] load_val,
  input  logic [PCW-1:0] pc_q,
  output logic [PCW-1:0] pc_d
);

  localparam logic [PCW-1:0] STEP = PCW'(pcstep);

  always_comb begin
    pc_d = pc_q;
    unique case (pc_select(load_en, pc_next))
      PC_SEL_LOAD:    pc_d = load_val;
      PC_SEL_ADVANCE: pc_d = pc_q + STEP;
      default:        pc_d = pc_q;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// RISC-V fetch-stage program counter with async active-low clear, load and advance.
// Optional macro PC_WORD_ALIGN_EN forces bits [1:0] of loaded values to zero.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int pcen   = 32,
  parameter int pcout  = 32,
  parameter int pcstep = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              clr_n,
  program_counter_if.slave  bus
);

  localparam int PCW = pcout + 1;

  logic [pcen:0]  load_w;
  logic [pcout:0] load_adj;
  logic [pcout:0] load_val;
  logic [pcout:0] pc_d;
  logic [pcout:0] pc_q;

  assign load_w = bus.load;

  // Zero-extend a narrower load bus, truncate a wider one to the pc width.
  generate
    if (pcen >= pcout) begin : g_load_trunc
      assign load_adj = load_w[pcout:0];
    end else begin : g_load_zext
      assign load_adj = {{(pcout - pcen){1'b0}}, load_w};
    end
  endgenerate

`ifdef PC_WORD_ALIGN_EN
  assign load_val = load_adj & ~PCW'(3);
`else
  assign load_val = load_adj;
`endif

  pc_next_mux #(
    .PCW    (PCW),
    .pcstep (pcstep)
  ) u_pc_next_mux (
    .load_en  (bus.load_en),
    .pc_next  (bus.pc_next),
    .load_val (load_val),
    .pc_q     (pc_q),
    .pc_d     (pc_d)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_q <= PCW'(PC_RESET_VALUE);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter: clear, hold, load, advance,
// load-over-advance priority, wrap and load alignment.
module tb_program_counter;

  localparam int PCEN  = 32;
  localparam int PCOUT = 32;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  program_counter_if #(.pcen(PCEN), .pcout(PCOUT)) bus ();

  program_counter #(
    .pcen   (PCEN),
    .pcout  (PCOUT),
    .pcstep (4)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PCOUT:0] got, input logic [PCOUT:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: pc=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: pc=%h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.load_en = 1'b0;
    bus.pc_next = 1'b0;
    bus.load    = 33'd16;

    // Clear held low: pc stays 0 across edges, even with load requested.
    tick();
    check("clr_low_0", bus.pc, 33'd0);
    bus.load_en = 1'b1;
    tick();
    check("clr_low_load", bus.pc, 33'd0);
    bus.pc_next = 1'b1;
    tick();
    check("clr_low_adv", bus.pc, 33'd0);
    bus.load_en = 1'b0;
    bus.pc_next = 1'b0;

    // Release at 100 ns (a falling edge) with no control asserted.
    while ($time < 100) @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_hold", bus.pc, 33'd0);
    end

    // Load 16, hold it while load_en stays high.
    bus.load_en = 1'b1;
    bus.load    = 33'd16;
    tick();
    check("load16", bus.pc, 33'd16);
    tick();
    check("load16_stay", bus.pc, 33'd16);

    // Asynchronous clear mid-cycle while load_en is high.
    #3;
    clr_n = 1'b0;
    #1;
    check("async_clr", bus.pc, 33'd0);
    tick();
    check("async_clr_hold", bus.pc, 33'd0);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    check("release_no_update", bus.pc, 33'd0);
    tick();
    check("first_edge_load", bus.pc, 33'd16);

    // Sequential advance from 0x10.
    bus.load = 33'h10;
    tick();
    check("load_10", bus.pc, 33'h10);
    bus.load_en = 1'b0;
    bus.pc_next = 1'b1;
    tick();
    check("adv_14", bus.pc, 33'h14);
    tick();
    check("adv_18", bus.pc, 33'h18);
    tick();
    check("adv_1c", bus.pc, 33'h1C);
    bus.pc_next = 1'b0;
    tick();
    check("hold_1c", bus.pc, 33'h1C);

    // Load and advance together: load wins.
    bus.load_en = 1'b1;
    bus.pc_next = 1'b1;
    bus.load    = 33'h100;
    tick();
    check("load_wins", bus.pc, 33'h100);
    bus.load_en = 1'b0;
    tick();
    check("adv_104", bus.pc, 33'h104);

    // Wrap at the top of the 33-bit address space.
    bus.load_en = 1'b1;
    bus.pc_next = 1'b0;
    bus.load    = 33'h1_FFFF_FFFC;
    tick();
    check("load_max", bus.pc, 33'h1_FFFF_FFFC);
    bus.load_en = 1'b0;
    bus.pc_next = 1'b1;
    tick();
    check("wrap_0", bus.pc, 33'h0);
    tick();
    check("wrap_4", bus.pc, 33'h4);

    // Load alignment behaviour.
    bus.load_en = 1'b1;
    bus.pc_next = 1'b0;
    bus.load    = 33'h13;
    tick();
`ifdef PC_WORD_ALIGN_EN
    check("load_13", bus.pc, 33'h10);
`else
    check("load_13", bus.pc, 33'h13);
`endif
    bus.load = 33'h1_FFFF_FFFF;
    tick();
`ifdef PC_WORD_ALIGN_EN
    check("load_ones", bus.pc, 33'h1_FFFF_FFFC);
`else
    check("load_ones", bus.pc, 33'h1_FFFF_FFFF);
`endif
    bus.load_en = 1'b0;
    bus.pc_next = 1'b1;
    tick();
`ifdef PC_WORD_ALIGN_EN
    check("wrap_ones", bus.pc, 33'h0);
`else
    check("wrap_ones", bus.pc, 33'h3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
